uart_scoreboard: RTL

UART_SCOREBOARD -- requirements
Module: uart_scoreboard

---
 rtl/uart_sb_pkg.sv | 16 +
 rtl/uart_sb_fifo.sv | 73 +++++++
 rtl/uart_scoreboard.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_sb_pkg.sv
// Shared types and default sizing for the UART scoreboard.
package uart_sb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sb_state_e;

  localparam int SB_DATA_WIDTH = 8;
  localparam int SB_DEPTH      = 16;
  localparam int SB_CNT_WIDTH  = 16;
  localparam int SB_TIMEOUT    = 1024;

endpackage

// File: rtl/uart_sb_fifo.sv
// sync_fifo: single-clock FIFO with flush, show-ahead read and simultaneous push/pop on full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full queue only succeeds when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_scoreboard.sv
// uart_scoreboard: matches received UART bytes against an in-order queue of expected bytes,
// counting matches and errors, with a drain phase bounded by an idle timeout.
module uart_scoreboard
  import uart_sb_pkg::*;
#(
  parameter int DATA_WIDTH = SB_DATA_WIDTH,
  parameter int DEPTH      = SB_DEPTH,
  parameter int CNT_WIDTH  = SB_CNT_WIDTH,
  parameter int TIMEOUT    = SB_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  end_test,
  input  logic                  exp_valid,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  obs_valid,
  input  logic [DATA_WIDTH-1:0] obs_data,
  input  logic                  obs_frame_err,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic                  overflow,
  output logic                  unexpected,
  output logic                  busy,
  output logic                  done,
  output logic                  pass
);

  localparam int QW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = CNT_WIDTH + QW + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  sb_state_e             state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [CNT_WIDTH-1:0]  error_count_q, error_count_d;
  logic [CNT_WIDTH-1:0]  match_count_q, match_count_d;
  logic                  overflow_q, overflow_d;
  logic                  unexpected_q, unexpected_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;

  logic                  flush, push_en, pop_en, clear, active, match_hit;
  logic [SW-1:0]         err_inc, err_sum;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  fifo_full, fifo_empty;
  logic [QW-1:0]         fifo_count;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push_en),
    .pop     (pop_en),
    .wr_data (exp_data),
    .rd_data (head_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    timer_d       = '0;
    error_count_d = error_count_q;
    match_count_d = match_count_q;
    overflow_d    = overflow_q;
    unexpected_d  = unexpected_q;
    flush         = 1'b0;
    push_en       = 1'b0;
    pop_en        = 1'b0;
    clear         = 1'b0;
    match_hit     = 1'b0;
    err_inc       = '0;
    active        = (state_q == RUN) || (state_q == DRAIN);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          flush   = 1'b1;
          clear   = 1'b1;
        end
      end
      RUN: begin
        push_en = exp_valid;
        if (end_test) begin
          state_d = DRAIN;
          timer_d = TW'(TIMEOUT);
        end
      end
      DRAIN: begin
        // Timing out charges every byte still waiting as an error and abandons it.
        if (fifo_empty) begin
          state_d = DONE;
        end else if (obs_valid) begin
          timer_d = TW'(TIMEOUT);
        end else if (timer_q == '0) begin
          flush   = 1'b1;
          err_inc = SW'(fifo_count);
          state_d = DONE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (active && obs_valid) begin
      if (fifo_empty) begin
        unexpected_d = 1'b1;
        err_inc      = err_inc + SW'(1);
      end else begin
        pop_en = 1'b1;
        if ((head_data == obs_data) && !obs_frame_err) begin
          match_hit = 1'b1;
        end else begin
          err_inc = err_inc + SW'(1);
        end
      end
    end

    if (push_en && fifo_full && !pop_en) begin
      overflow_d = 1'b1;
      err_inc    = err_inc + SW'(1);
    end

    err_sum       = SW'(error_count_q) + err_inc;
    error_count_d = (err_sum > SW'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_WIDTH-1:0];
    if (match_hit && (match_count_q != CNT_MAX)) begin
      match_count_d = match_count_q + CNT_WIDTH'(1);
    end

    if (clear) begin
      error_count_d = '0;
      match_count_d = '0;
      overflow_d    = 1'b0;
      unexpected_d  = 1'b0;
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = done_d && (error_count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      error_count_q <= '0;
      match_count_q <= '0;
      overflow_q    <= 1'b0;
      unexpected_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      error_count_q <= error_count_d;
      match_count_q <= match_count_d;
      overflow_q    <= overflow_d;
      unexpected_q  <= unexpected_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
    end
  end

  assign error_count = error_count_q;
  assign match_count = match_count_q;
  assign overflow    = overflow_q;
  assign unexpected  = unexpected_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;

endmodule
